key_event_queue: RTL and testbench
==================================

Name: key_event_queue

Overview:
- CPU-side receiver for the key input device's event stream.
- Captures each one-cycle event pulse and its 32-bit event word into a FIFO, and holds a level interrupt toward the CPU while events are pending.
- The CPU pops one word per read strobe. A popped word of 32'h0 means "no event".
- Sits between the key device (irq/out pair) and the CPU I/O read mux.

Parameters:
- DEPTH, 8, FIFO entries; power of two, 2..256
- ADDR_W, 3, log2(DEPTH)

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- ev_valid  in  1  one-cycle event strobe (key device irq)
- ev_word  in  32  event word; [31:24] type, [23:5] reserved, [4:0] key mask
- rd_en  in  1  CPU pop strobe, one cycle
- irq_en  in  1  interrupt enable
- clr_ovf  in  1  clears sticky overflow flag
- rd_data  out  32  popped word, registered
- rd_valid  out  1  one-cycle pulse; rd_data is valid this cycle
- count  out  ADDR_W+1  entries currently stored, 0..DEPTH
- empty  out  1  count==0
- full  out  1  count==DEPTH
- ovf  out  1  sticky: an event was dropped because the FIFO was full
- irq  out  1  registered level interrupt

Behaviour:
- Reset values (async, immediate): rd_data=0, rd_valid=0, count=0, empty=1, full=0, ovf=0, irq=0. Write/read pointers are 0. Reset mid-operation discards all stored entries.
- Accept rule: a push occurs on a clk edge with ev_valid=1, ev_word[31:24]!=0, and (not full, or a pop occurring in the same cycle).
  - ev_valid with type byte 0: ignored; no push, no ovf.
- Drop rule: ev_valid=1, type!=0, full=1, rd_en=0 -> word discarded, ovf<=1.
- Pop rule: rd_en=1 and empty=0 -> rd_data<=mem[rptr], rd_valid<=1, rptr<=rptr+1.
  - Latency: the word appears one clock after the strobe.
- Empty read: rd_en=1 and empty=1 -> rd_data<=32'h0, rd_valid<=1; pointers unchanged.
  - No write-to-read bypass: a simultaneous push on an empty FIFO is stored, and the read still returns 0.
- Simultaneous push and pop with count>0: both occur; count unchanged.
  - When full, this is legal and is not an overflow.
- rd_valid is 0 in any cycle not following an rd_en.
- rd_data holds its last value when there is no pop.
- Pointers wrap modulo DEPTH.
- count = count + push - pop, saturating behaviour never needed by construction.
- empty and full are combinational from count.
- ovf: set has priority over clr_ovf in the same cycle. Otherwise clr_ovf=1 -> ovf<=0. ovf does not affect storage.
- irq register: irq <= irq_en & (count_next != 0), where count_next is the post-edge count.
  - irq rises on the same edge that stores the first event.
  - irq falls on the same edge that pops the last event.
  - Deasserting irq_en drops irq on the next edge; the FIFO contents are retained.
- FIFO ordering is strict first-in first-out. Words are stored unmodified, including reserved bits.
- Implementation: register-array FIFO with one write port and one read port. No combinational path from ev_* or rd_en to any output.

Test Plan:
- Reset, then irq_en=1, then one pulse ev_word=32'h0100_0005 -> count=1, irq=1 after that edge. rd_en pulse -> next cycle rd_data=32'h0100_0005, rd_valid=1, count=0, irq=0.
- Push 3 words 32'h0100_0001/02/04 on consecutive cycles, then 3 pops -> rd_data returns 01, 02, 04 in order. A 4th pop -> rd_data=0 with rd_valid=1.
- Push DEPTH+1 (9) distinct words -> full=1 after 8, ovf=1 after 9th, count=8. Pop all -> first 8 words returned, 9th absent. Pulse clr_ovf -> ovf=0.
- With FIFO full, ev_valid and rd_en in the same cycle -> ovf stays 0, count stays 8, oldest word popped, new word stored last.
- ev_valid with ev_word=32'h0000_0003 -> count stays 0, irq stays 0. Also: irq_en=0 with 2 stored events -> irq=0, count=2; setting irq_en=1 -> irq=1 next edge.
- Assert rst asynchronously mid-cycle with count=5 and ovf=1 -> all outputs return to reset values immediately. A subsequent pop returns 32'h0.

Source files
------------

// File: rtl/key_event_queue.sv
// Key-event FIFO between the key device and the CPU read mux: pushes typed event words, pops one per rd_en.
// Read data and rd_valid appear one clock after rd_en; a push into a full FIFO without a same-cycle pop is dropped and flagged in ovf.
module key_event_queue #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ev_valid,
  input  logic [31:0]       ev_word,
  input  logic              rd_en,
  input  logic              irq_en,
  input  logic              clr_ovf,
  output logic [31:0]       rd_data,
  output logic              rd_valid,
  output logic [ADDR_W:0]   count,
  output logic              empty,
  output logic              full,
  output logic              ovf,
  output logic              irq
);

  localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

  logic [31:0]       mem_q [DEPTH];
  logic [ADDR_W-1:0] wptr_q, wptr_d;
  logic [ADDR_W-1:0] rptr_q, rptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [31:0]       rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              ovf_q, ovf_d;
  logic              irq_q, irq_d;

  logic empty_w, full_w, typed_ev, push, pop, drop;

  assign empty_w  = (count_q == '0);
  assign full_w   = (count_q == CNT_FULL);
  // Type byte 0 is the device's idle word and is never queued.
  assign typed_ev = ev_valid && (ev_word[31:24] != 8'h00);
  assign pop      = rd_en && !empty_w;
  assign push     = typed_ev && (!full_w || rd_en);
  assign drop     = typed_ev && full_w && !rd_en;

  always_comb begin
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    count_d    = count_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = rd_en;
    ovf_d      = ovf_q;

    if (push) begin
      wptr_d = wptr_q + PTR_ONE;
    end
    if (pop) begin
      rptr_d    = rptr_q + PTR_ONE;
      rd_data_d = mem_q[rptr_q];
    end else if (rd_en) begin
      // Empty read returns "no event" even if a push lands this same edge.
      rd_data_d = 32'h0;
    end

    count_d = count_q + (push ? CNT_ONE : '0) - (pop ? CNT_ONE : '0);

    if (drop) begin
      ovf_d = 1'b1;
    end else if (clr_ovf) begin
      ovf_d = 1'b0;
    end

    irq_d = irq_en && (count_d != '0);
  end

  // When full with a same-cycle pop, wptr==rptr: the read sees the old word, the new one replaces it at the tail.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wptr_q] <= ev_word;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      rd_data_q  <= 32'h0;
      rd_valid_q <= 1'b0;
      ovf_q      <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      ovf_q      <= ovf_d;
      irq_q      <= irq_d;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign count    = count_q;
  assign empty    = empty_w;
  assign full     = full_w;
  assign ovf      = ovf_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_key_event_queue.sv
// Directed bench for key_event_queue: scenario tasks with hand-computed expectations.
module tb_key_event_queue;

  logic        clk;
  logic        rst;
  logic        ev_valid;
  logic [31:0] ev_word;
  logic        rd_en;
  logic        irq_en;
  logic        clr_ovf;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic [3:0]  count;
  logic        empty;
  logic        full;
  logic        ovf;
  logic        irq;

  int vectors;
  int miscompares;

  key_event_queue #(.DEPTH(8), .ADDR_W(3)) dut (
    .clk      (clk),
    .rst      (rst),
    .ev_valid (ev_valid),
    .ev_word  (ev_word),
    .rd_en    (rd_en),
    .irq_en   (irq_en),
    .clr_ovf  (clr_ovf),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .count    (count),
    .empty    (empty),
    .full     (full),
    .ovf      (ovf),
    .irq      (irq)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One clock with the given strobes; returns 1 time unit after the edge.
  task automatic cyc(input logic ev_v, input logic [31:0] w, input logic rd, input logic clr);
    ev_valid = ev_v;
    ev_word  = w;
    rd_en    = rd;
    clr_ovf  = clr;
    @(posedge clk);
    #1;
    ev_valid = 1'b0;
    ev_word  = 32'h0;
    rd_en    = 1'b0;
    clr_ovf  = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    vectors++; if (rd_data !== 32'h0) begin miscompares++; $display("FAIL reset_rd_data got %h exp %h", rd_data, 32'h0); end
    vectors++; if (rd_valid !== 1'b0) begin miscompares++; $display("FAIL reset_rd_valid got %b exp 0", rd_valid); end
    vectors++; if (count !== 4'd0) begin miscompares++; $display("FAIL reset_count got %0d exp 0", count); end
    vectors++; if (empty !== 1'b1) begin miscompares++; $display("FAIL reset_empty got %b exp 1", empty); end
    vectors++; if (full !== 1'b0) begin miscompares++; $display("FAIL reset_full got %b exp 0", full); end
    vectors++; if (ovf !== 1'b0) begin miscompares++; $display("FAIL reset_ovf got %b exp 0", ovf); end
    vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL reset_irq got %b exp 0", irq); end
    #1 rst = 1'b0;
  endtask

  task automatic test_single();
    irq_en = 1'b1;
    cyc(1'b1, 32'h0100_0005, 1'b0, 1'b0);
    vectors++; if (count !== 4'd1) begin miscompares++; $display("FAIL single_count got %0d exp 1", count); end
    vectors++; if (irq !== 1'b1) begin miscompares++; $display("FAIL single_irq_rise got %b exp 1", irq); end
    vectors++; if (empty !== 1'b0) begin miscompares++; $display("FAIL single_empty got %b exp 0", empty); end
    cyc(1'b0, 32'h0, 1'b1, 1'b0);
    vectors++; if (rd_data !== 32'h0100_0005) begin miscompares++; $display("FAIL single_rd_data got %h exp %h", rd_data, 32'h0100_0005); end
    vectors++; if (rd_valid !== 1'b1) begin miscompares++; $display("FAIL single_rd_valid got %b exp 1", rd_valid); end
    vectors++; if (count !== 4'd0) begin miscompares++; $display("FAIL single_count_after got %0d exp 0", count); end
    vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL single_irq_fall got %b exp 0", irq); end
    cyc(1'b0, 32'h0, 1'b0, 1'b0);
    vectors++; if (rd_valid !== 1'b0) begin miscompares++; $display("FAIL idle_rd_valid got %b exp 0", rd_valid); end
    vectors++; if (rd_data !== 32'h0100_0005) begin miscompares++; $display("FAIL idle_rd_data_hold got %h exp %h", rd_data, 32'h0100_0005); end
  endtask

  task automatic test_order();
    logic [31:0] words [3];
    words[0] = 32'h0100_0001; words[1] = 32'h0100_0002; words[2] = 32'h0100_0004;
    for (int i = 0; i < 3; i++) cyc(1'b1, words[i], 1'b0, 1'b0);
    vectors++; if (count !== 4'd3) begin miscompares++; $display("FAIL order_count got %0d exp 3", count); end
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 32'h0, 1'b1, 1'b0);
      vectors++; if (rd_data !== words[i]) begin miscompares++; $display("FAIL order_pop%0d got %h exp %h", i, rd_data, words[i]); end
    end
    cyc(1'b0, 32'h0, 1'b1, 1'b0);
    vectors++; if (rd_data !== 32'h0) begin miscompares++; $display("FAIL empty_read_data got %h exp 0", rd_data); end
    vectors++; if (rd_valid !== 1'b1) begin miscompares++; $display("FAIL empty_read_valid got %b exp 1", rd_valid); end
  endtask

  task automatic test_empty_push();
    cyc(1'b1, 32'h07AB_CDEF, 1'b1, 1'b0);
    vectors++; if (rd_data !== 32'h0) begin miscompares++; $display("FAIL nobypass_data got %h exp 0", rd_data); end
    vectors++; if (count !== 4'd1) begin miscompares++; $display("FAIL nobypass_count got %0d exp 1", count); end
    cyc(1'b0, 32'h0, 1'b1, 1'b0);
    vectors++; if (rd_data !== 32'h07AB_CDEF) begin miscompares++; $display("FAIL nobypass_stored got %h exp %h", rd_data, 32'h07AB_CDEF); end
  endtask

  task automatic test_overflow();
    logic [31:0] w;
    for (int i = 0; i < 9; i++) begin
      w = 32'h0200_0000 + 32'(i);
      cyc(1'b1, w, 1'b0, 1'b0);
      if (i == 7) begin
        vectors++; if (full !== 1'b1) begin miscompares++; $display("FAIL ovf_full8 got %b exp 1", full); end
        vectors++; if (ovf !== 1'b0) begin miscompares++; $display("FAIL ovf_early got %b exp 0", ovf); end
      end
    end
    vectors++; if (ovf !== 1'b1) begin miscompares++; $display("FAIL ovf_set got %b exp 1", ovf); end
    vectors++; if (count !== 4'd8) begin miscompares++; $display("FAIL ovf_count got %0d exp 8", count); end
    cyc(1'b1, 32'h02FF_FFFF, 1'b0, 1'b1);
    vectors++; if (ovf !== 1'b1) begin miscompares++; $display("FAIL ovf_set_priority got %b exp 1", ovf); end
    for (int i = 0; i < 8; i++) begin
      w = 32'h0200_0000 + 32'(i);
      cyc(1'b0, 32'h0, 1'b1, 1'b0);
      vectors++; if (rd_data !== w) begin miscompares++; $display("FAIL ovf_pop%0d got %h exp %h", i, rd_data, w); end
    end
    vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL ovf_irq_drained got %b exp 0", irq); end
    cyc(1'b0, 32'h0, 1'b1, 1'b0);
    vectors++; if (rd_data !== 32'h0) begin miscompares++; $display("FAIL ovf_ninth_absent got %h exp 0", rd_data); end
    cyc(1'b0, 32'h0, 1'b0, 1'b1);
    vectors++; if (ovf !== 1'b0) begin miscompares++; $display("FAIL ovf_clear got %b exp 0", ovf); end
  endtask

  task automatic test_full_simul();
    logic [31:0] w;
    for (int i = 0; i < 8; i++) cyc(1'b1, 32'h0300_0000 + 32'(i), 1'b0, 1'b0);
    cyc(1'b1, 32'h0300_00AA, 1'b1, 1'b0);
    vectors++; if (rd_data !== 32'h0300_0000) begin miscompares++; $display("FAIL simul_oldest got %h exp %h", rd_data, 32'h0300_0000); end
    vectors++; if (count !== 4'd8) begin miscompares++; $display("FAIL simul_count got %0d exp 8", count); end
    vectors++; if (ovf !== 1'b0) begin miscompares++; $display("FAIL simul_ovf got %b exp 0", ovf); end
    vectors++; if (full !== 1'b1) begin miscompares++; $display("FAIL simul_full got %b exp 1", full); end
    for (int i = 1; i < 9; i++) begin
      w = (i == 8) ? 32'h0300_00AA : 32'h0300_0000 + 32'(i);
      cyc(1'b0, 32'h0, 1'b1, 1'b0);
      vectors++; if (rd_data !== w) begin miscompares++; $display("FAIL simul_pop%0d got %h exp %h", i, rd_data, w); end
    end
  endtask

  task automatic test_type_zero();
    cyc(1'b1, 32'h0000_0003, 1'b0, 1'b0);
    vectors++; if (count !== 4'd0) begin miscompares++; $display("FAIL type0_count got %0d exp 0", count); end
    vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL type0_irq got %b exp 0", irq); end
    vectors++; if (ovf !== 1'b0) begin miscompares++; $display("FAIL type0_ovf got %b exp 0", ovf); end
  endtask

  task automatic test_irq_en();
    irq_en = 1'b0;
    cyc(1'b1, 32'h0500_0001, 1'b0, 1'b0);
    cyc(1'b1, 32'h0500_0002, 1'b0, 1'b0);
    vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL irqen_off got %b exp 0", irq); end
    vectors++; if (count !== 4'd2) begin miscompares++; $display("FAIL irqen_count got %0d exp 2", count); end
    irq_en = 1'b1;
    cyc(1'b0, 32'h0, 1'b0, 1'b0);
    vectors++; if (irq !== 1'b1) begin miscompares++; $display("FAIL irqen_on got %b exp 1", irq); end
    irq_en = 1'b0;
    cyc(1'b0, 32'h0, 1'b0, 1'b0);
    vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL irqen_drop got %b exp 0", irq); end
    vectors++; if (count !== 4'd2) begin miscompares++; $display("FAIL irqen_retain got %0d exp 2", count); end
    irq_en = 1'b1;
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 7; i++) cyc(1'b1, 32'h0600_0000 + 32'(i), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 32'h0, 1'b1, 1'b0);
    vectors++; if (count !== 4'd5) begin miscompares++; $display("FAIL prerst_count got %0d exp 5", count); end
    vectors++; if (ovf !== 1'b1) begin miscompares++; $display("FAIL prerst_ovf got %b exp 1", ovf); end
    vectors++; if (rd_data !== 32'h0600_0000) begin miscompares++; $display("FAIL prerst_rd_data got %h exp %h", rd_data, 32'h0600_0000); end
    #2 rst = 1'b1;
    #1;
    vectors++; if (rd_data !== 32'h0) begin miscompares++; $display("FAIL arst_rd_data got %h exp 0", rd_data); end
    vectors++; if (rd_valid !== 1'b0) begin miscompares++; $display("FAIL arst_rd_valid got %b exp 0", rd_valid); end
    vectors++; if (count !== 4'd0) begin miscompares++; $display("FAIL arst_count got %0d exp 0", count); end
    vectors++; if (empty !== 1'b1) begin miscompares++; $display("FAIL arst_empty got %b exp 1", empty); end
    vectors++; if (ovf !== 1'b0) begin miscompares++; $display("FAIL arst_ovf got %b exp 0", ovf); end
    vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL arst_irq got %b exp 0", irq); end
    #1 rst = 1'b0;
    cyc(1'b0, 32'h0, 1'b1, 1'b0);
    vectors++; if (rd_data !== 32'h0) begin miscompares++; $display("FAIL postrst_pop got %h exp 0", rd_data); end
    vectors++; if (rd_valid !== 1'b1) begin miscompares++; $display("FAIL postrst_valid got %b exp 1", rd_valid); end
    vectors++; if (count !== 4'd0) begin miscompares++; $display("FAIL postrst_count got %0d exp 0", count); end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst      = 1'b1;
    ev_valid = 1'b0;
    ev_word  = 32'h0;
    rd_en    = 1'b0;
    irq_en   = 1'b0;
    clr_ovf  = 1'b0;
    test_reset();
    test_single();
    test_order();
    test_empty_push();
    test_overflow();
    test_full_simul();
    test_type_zero();
    test_irq_en();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
